// File: rtl/weights_ddr_rd_cmd_issuer.sv
// Splits one (base, length) weights read into single-word MIG reads with at most MAX_OUTSTANDING in flight.
// Read data is forwarded with 1-cycle latency; issue stalls on app_rdy=0 or the outstanding cap; commands are refused while busy.
module weights_ddr_rd_cmd_issuer #(
   parameter int APP_ADDR_W      = 29,
   parameter int ADDR_STEP       = 8,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_load_weights_ddr_cmd,
   input  logic [31:0]           load_weights_ddr_base_adr,
   input  logic [15:0]           load_weights_ddr_length,
   output logic                  ddr_cmd_ready,
   input  logic                  app_rdy,
   output logic                  app_en,
   output logic [2:0]            app_cmd,
   output logic [APP_ADDR_W-1:0] app_addr,
   input  logic [511:0]          app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic [511:0]          ddr_rd_data,
   output logic                  ddr_rd_data_valid,
   output logic                  cmd_done,
   output logic                  rd_spurious_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   localparam logic [7:0]  LP_MAX_OUT = 8'(MAX_OUTSTANDING);
   localparam logic [63:0] LP_STEP    = 64'(ADDR_STEP);

   state_t          r_state;
   logic [31:0]     r_base;
   logic [15:0]     r_len;
   logic [15:0]     r_issued;
   logic [15:0]     r_received;
   logic [7:0]      r_outstanding;
   logic            r_ddr_cmd_ready;
   logic            r_cmd_done;
   logic            r_ddr_rd_data_valid;
   logic [511:0]    r_ddr_rd_data;
   logic            r_rd_spurious_err;

   logic            w_app_en;
   logic            w_accept;
   logic            w_rd_ok;
   logic [15:0]     w_issued_nxt;
   logic [APP_ADDR_W-1:0] w_addr;

   // Request valid only depends on registered state, so it cannot drop before acceptance.
   assign w_app_en     = (r_state == S_ISSUE) && (r_issued < r_len) && (r_outstanding < LP_MAX_OUT);
   assign w_accept     = w_app_en & app_rdy;
   assign w_rd_ok      = app_rd_data_valid && (r_outstanding != 8'd0);
   assign w_issued_nxt = r_issued + 16'd1;
   assign w_addr       = APP_ADDR_W'((64'(r_base) + 64'(r_issued)) * LP_STEP);

   assign app_en            = w_app_en;
   assign app_cmd           = 3'b001;
   assign app_addr          = w_addr;
   assign ddr_cmd_ready     = r_ddr_cmd_ready;
   assign cmd_done          = r_cmd_done;
   assign ddr_rd_data       = r_ddr_rd_data;
   assign ddr_rd_data_valid = r_ddr_rd_data_valid;
   assign rd_spurious_err   = r_rd_spurious_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state             <= S_IDLE;
         r_base              <= 32'd0;
         r_len               <= 16'd0;
         r_issued            <= 16'd0;
         r_received          <= 16'd0;
         r_outstanding       <= 8'd0;
         r_ddr_cmd_ready     <= 1'b1;
         r_cmd_done          <= 1'b0;
         r_ddr_rd_data_valid <= 1'b0;
         r_ddr_rd_data       <= 512'd0;
         r_rd_spurious_err   <= 1'b0;
      end else begin
         r_cmd_done          <= 1'b0;
         r_ddr_rd_data_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_ddr_rd_data <= app_rd_data;
            r_received    <= r_received + 16'd1;
         end
         // Data with nothing in flight (e.g. stale beats after a reset) is dropped and flagged.
         if (app_rd_data_valid && (r_outstanding == 8'd0))
            r_rd_spurious_err <= 1'b1;

         unique case ({w_accept, w_rd_ok})
            2'b10:   r_outstanding <= r_outstanding + 8'd1;
            2'b01:   r_outstanding <= r_outstanding - 8'd1;
            default: r_outstanding <= r_outstanding;
         endcase

         case (r_state)
            S_IDLE: begin
               if (valid_load_weights_ddr_cmd) begin
                  r_base     <= load_weights_ddr_base_adr;
                  r_len      <= load_weights_ddr_length;
                  r_issued   <= 16'd0;
                  r_received <= 16'd0;
                  if (load_weights_ddr_length == 16'd0) begin
                     r_cmd_done <= 1'b1;
                  end else begin
                     r_state         <= S_ISSUE;
                     r_ddr_cmd_ready <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               if (w_accept) begin
                  r_issued <= w_issued_nxt;
                  if (w_issued_nxt == r_len)
                     r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_received == r_len) begin
                  r_cmd_done      <= 1'b1;
                  r_ddr_cmd_ready <= 1'b1;
                  r_state         <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weights_ddr_rd_cmd_issuer.sv
// Bench for weights_ddr_rd_cmd_issuer: MIG model plus address/data scoreboards, one task per scenario.
module tb_weights_ddr_rd_cmd_issuer;
   localparam int AW   = 29;
   localparam int STEP = 8;
   localparam int MAXO = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           valid_cmd;
   logic [31:0]    base_in;
   logic [15:0]    len_in;
   logic           ddr_cmd_ready;
   logic           app_rdy;
   logic           app_en;
   logic [2:0]     app_cmd;
   logic [AW-1:0]  app_addr;
   logic [511:0]   app_rd_data;
   logic           app_rd_data_valid;
   logic [511:0]   ddr_rd_data;
   logic           ddr_rd_data_valid;
   logic           cmd_done;
   logic           rd_spurious_err;

   weights_ddr_rd_cmd_issuer #(.APP_ADDR_W(AW), .ADDR_STEP(STEP), .MAX_OUTSTANDING(MAXO)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .valid_load_weights_ddr_cmd (valid_cmd),
      .load_weights_ddr_base_adr  (base_in),
      .load_weights_ddr_length    (len_in),
      .ddr_cmd_ready              (ddr_cmd_ready),
      .app_rdy                    (app_rdy),
      .app_en                     (app_en),
      .app_cmd                    (app_cmd),
      .app_addr                   (app_addr),
      .app_rd_data                (app_rd_data),
      .app_rd_data_valid          (app_rd_data_valid),
      .ddr_rd_data                (ddr_rd_data),
      .ddr_rd_data_valid          (ddr_rd_data_valid),
      .cmd_done                   (cmd_done),
      .rd_spurious_err            (rd_spurious_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [AW-1:0]  exp_addr[$];
   logic [511:0]   exp_data[$];
   int             ret_cyc[$];
   int             acc_q[$];

   int  lat          = 3;
   int  hold_until   = 0;
   int  rdy_mode     = 0;
   int  accept_limit = 32'h7fffffff;
   bit  fwd_ok       = 1'b1;

   int  acc_total    = 0;
   int  bench_out    = 0;
   int  max_out      = 0;
   int  done_cnt     = 0;
   int  done_cyc     = -1;
   int  fwd_cnt      = 0;
   int  last_fwd_cyc = -10;
   int  en_cycles    = 0;
   int  hold_checks  = 0;
   bit  ready_at_done     = 1'b0;
   bit  ready_before_done = 1'b0;
   bit  prev_ready        = 1'b1;
   bit  exp_fwd_prev      = 1'b0;
   bit  prev_wait         = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   logic           m_rdy;
   logic [511:0]   m_d;
   logic [AW-1:0]  m_a;

   // MIG model and scoreboards: checks outputs of the last edge, then drives inputs for the next one.
   always @(negedge clk) begin
      cyc++;
      if (ddr_rd_data_valid === 1'b1 || exp_fwd_prev) begin
         n_checks++;
         if (ddr_rd_data_valid !== exp_fwd_prev) begin
            n_fail++;
            $display("FAIL fwd_valid cyc=%0d got=%b want=%b", cyc, ddr_rd_data_valid, exp_fwd_prev);
         end else if (exp_data.size() > 0) begin
            m_d = exp_data.pop_front();
            n_checks++;
            if (ddr_rd_data !== m_d) begin
               n_fail++;
               $display("FAIL fwd_data cyc=%0d got=%h want=%h", cyc, ddr_rd_data[63:0], m_d[63:0]);
            end
            fwd_cnt++;
            last_fwd_cyc = cyc;
         end
      end
      if (cmd_done === 1'b1) begin
         done_cnt++;
         done_cyc          = cyc;
         ready_at_done     = ddr_cmd_ready;
         ready_before_done = prev_ready;
      end
      prev_ready = ddr_cmd_ready;
      if (prev_wait && reset !== 1'b1) begin
         n_checks++;
         hold_checks++;
         if (app_en !== 1'b1 || app_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL addr_hold cyc=%0d got en=%b addr=%h want en=1 addr=%h", cyc, app_en, app_addr, prev_addr);
         end
      end
      if (app_en === 1'b1) en_cycles++;

      m_rdy = ((rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0)) && (acc_total < accept_limit);
      app_rdy   = m_rdy;
      prev_wait = (app_en === 1'b1) && !m_rdy;
      prev_addr = app_addr;
      if (app_en === 1'b1 && m_rdy) begin
         n_checks++;
         if (bench_out >= MAXO) begin
            n_fail++;
            $display("FAIL outstanding_limit cyc=%0d got=%0d in flight at issue want<%0d", cyc, bench_out, MAXO);
         end
         n_checks++;
         if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL issue_addr cyc=%0d got=%h want=no request", cyc, app_addr);
         end else begin
            m_a = exp_addr.pop_front();
            if (app_addr !== m_a) begin
               n_fail++;
               $display("FAIL issue_addr cyc=%0d got=%h want=%h", cyc, app_addr, m_a);
            end
         end
         acc_q.push_back(cyc);
         acc_total++;
         bench_out++;
         if (bench_out > max_out) max_out = bench_out;
         ret_cyc.push_back(cyc + lat);
      end

      exp_fwd_prev = 1'b0;
      if (ret_cyc.size() > 0 && ret_cyc[0] <= cyc && cyc >= hold_until) begin
         void'(ret_cyc.pop_front());
         for (int k = 0; k < 16; k++) m_d[k*32 +: 32] = $urandom();
         app_rd_data       = m_d;
         app_rd_data_valid = 1'b1;
         if (fwd_ok) begin
            exp_data.push_back(m_d);
            exp_fwd_prev = 1'b1;
            if (bench_out > 0) bench_out--;
         end
      end else begin
         app_rd_data_valid = 1'b0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] b, input logic [15:0] l, input bit expect_issue);
      logic [63:0] t;
      step();
      valid_cmd = 1'b1; base_in = b; len_in = l;
      if (expect_issue)
         for (int i = 0; i < int'(l); i++) begin
            t = (64'(b) + 64'(i)) * 64'(STEP);
            exp_addr.push_back(t[AW-1:0]);
         end
      step();
      valid_cmd = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin step(); n++; end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_checks += 8;
      if (ddr_cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_ready got=%b want=1", ddr_cmd_ready); end
      if (app_en !== 1'b0)            begin n_fail++; $display("FAIL rst_app_en got=%b want=0", app_en); end
      if (app_addr !== '0)            begin n_fail++; $display("FAIL rst_app_addr got=%h want=0", app_addr); end
      if (ddr_rd_data !== '0)         begin n_fail++; $display("FAIL rst_rd_data got=%h want=0", ddr_rd_data[63:0]); end
      if (ddr_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got=%b want=0", ddr_rd_data_valid); end
      if (cmd_done !== 1'b0)          begin n_fail++; $display("FAIL rst_cmd_done got=%b want=0", cmd_done); end
      if (rd_spurious_err !== 1'b0)   begin n_fail++; $display("FAIL rst_spurious got=%b want=0", rd_spurious_err); end
      if (app_cmd !== 3'b001)         begin n_fail++; $display("FAIL app_cmd got=%b want=001", app_cmd); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int d0, f0;
      acc_q.delete();
      lat = 3; rdy_mode = 0; d0 = done_cnt; f0 = fwd_cnt;
      exp_addr.push_back(29'h800);
      exp_addr.push_back(29'h808);
      exp_addr.push_back(29'h810);
      exp_addr.push_back(29'h818);
      send_cmd(32'h100, 16'd4, 1'b0);
      wait_done(d0, 60);
      n_checks += 6;
      if (done_cnt != d0 + 1)          begin n_fail++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0); end
      if (acc_q.size() != 4 || acc_q[acc_q.size()-1] - acc_q[0] != 3)
                                       begin n_fail++; $display("FAIL basic_consecutive got=%0d issues want=4 back to back", acc_q.size()); end
      if (fwd_cnt - f0 != 4)           begin n_fail++; $display("FAIL basic_words got=%0d want=4", fwd_cnt - f0); end
      if (done_cyc != last_fwd_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, last_fwd_cyc + 1); end
      if (ready_at_done !== 1'b1 || ready_before_done !== 1'b0)
                                       begin n_fail++; $display("FAIL basic_ready_rise got=%b%b want=01", ready_before_done, ready_at_done); end
      if (exp_addr.size() != 0)        begin n_fail++; $display("FAIL basic_missing_issue got=%0d left want=0", exp_addr.size()); end
   endtask

   task automatic test_outstanding();
      int d0, f0, a0, h, n;
      lat = 1; rdy_mode = 0; max_out = 0;
      d0 = done_cnt; f0 = fwd_cnt; a0 = acc_total;
      h = cyc + 30;
      hold_until = h;
      send_cmd(32'h5000, 16'd40, 1'b1);
      repeat (20) step();
      n_checks += 2;
      if (acc_total - a0 != 16) begin n_fail++; $display("FAIL limit_count got=%0d want=16", acc_total - a0); end
      if (app_en !== 1'b0)      begin n_fail++; $display("FAIL limit_app_en got=%b want=0", app_en); end
      n = 0;
      while (cyc < h + 2 && n < 100) begin step(); n++; end
      n_checks++;
      if (acc_total - a0 != 18) begin n_fail++; $display("FAIL limit_resume got=%0d want=18", acc_total - a0); end
      wait_done(d0, 300);
      n_checks += 4;
      if (done_cnt != d0 + 1)     begin n_fail++; $display("FAIL limit_done got=%0d want=1", done_cnt - d0); end
      if (acc_total - a0 != 40 || fwd_cnt - f0 != 40)
                                  begin n_fail++; $display("FAIL limit_words got=%0d/%0d want=40/40", acc_total - a0, fwd_cnt - f0); end
      if (max_out != MAXO)        begin n_fail++; $display("FAIL limit_peak got=%0d want=%0d", max_out, MAXO); end
      if (done_cyc != last_fwd_cyc + 1) begin n_fail++; $display("FAIL limit_done_timing got=%0d want=%0d", done_cyc, last_fwd_cyc + 1); end
      hold_until = 0;
   endtask

   task automatic test_rdy_toggle();
      int d0, a0, h0;
      lat = 2; rdy_mode = 1;
      d0 = done_cnt; a0 = acc_total; h0 = hold_checks;
      send_cmd(32'h03FF_FFFE, 16'd5, 1'b1);
      wait_done(d0, 80);
      n_checks += 4;
      if (done_cnt != d0 + 1)   begin n_fail++; $display("FAIL toggle_done got=%0d want=1", done_cnt - d0); end
      if (acc_total - a0 != 5)  begin n_fail++; $display("FAIL toggle_issues got=%0d want=5", acc_total - a0); end
      if (exp_addr.size() != 0) begin n_fail++; $display("FAIL toggle_skipped got=%0d left want=0", exp_addr.size()); end
      if (hold_checks == h0)    begin n_fail++; $display("FAIL toggle_stall got=0 stalled cycles want>0"); end
      rdy_mode = 0;
   endtask

   task automatic test_zero_len();
      int e0, a0;
      e0 = en_cycles; a0 = acc_total;
      step();
      valid_cmd = 1'b1; base_in = 32'h77; len_in = 16'd0;
      step();
      valid_cmd = 1'b0;
      n_checks += 2;
      if (cmd_done !== 1'b1)      begin n_fail++; $display("FAIL zero_done got=%b want=1", cmd_done); end
      if (ddr_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%b want=1", ddr_cmd_ready); end
      step();
      n_checks += 2;
      if (cmd_done !== 1'b0)      begin n_fail++; $display("FAIL zero_pulse got=%b want=0", cmd_done); end
      if (ddr_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready2 got=%b want=1", ddr_cmd_ready); end
      repeat (3) step();
      n_checks++;
      if (en_cycles != e0 || acc_total != a0) begin n_fail++; $display("FAIL zero_app_en got=%0d cycles want=0", en_cycles - e0); end
   endtask

   task automatic test_ignore();
      int d0, a0, n, rdy_hi;
      lat = 4; rdy_mode = 0;
      d0 = done_cnt; a0 = acc_total; rdy_hi = 0;
      send_cmd(32'h200, 16'd6, 1'b1);
      step(); step();
      valid_cmd = 1'b1; base_in = 32'h9000; len_in = 16'd3;
      n_checks++;
      if (ddr_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b want=0", ddr_cmd_ready); end
      step();
      valid_cmd = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         step();
         if (ddr_cmd_ready === 1'b1 && done_cnt == d0) rdy_hi++;
         n++;
      end
      repeat (5) step();
      n_checks += 5;
      if (done_cnt != d0 + 1)    begin n_fail++; $display("FAIL ignore_done got=%0d want=1", done_cnt - d0); end
      if (rdy_hi != 0)           begin n_fail++; $display("FAIL ignore_ready got=%0d early cycles want=0", rdy_hi); end
      if (acc_total - a0 != 6)   begin n_fail++; $display("FAIL ignore_issues got=%0d want=6", acc_total - a0); end
      if (exp_addr.size() != 0)  begin n_fail++; $display("FAIL ignore_missing got=%0d left want=0", exp_addr.size()); end
      if (rd_spurious_err !== 1'b0) begin n_fail++; $display("FAIL ignore_spurious got=%b want=0", rd_spurious_err); end
   endtask

   task automatic test_reset_mid();
      int f0, n;
      lat = 2; rdy_mode = 0;
      f0 = fwd_cnt;
      accept_limit = acc_total + 3;
      hold_until   = 32'h7fffffff;
      send_cmd(32'h40, 16'd8, 1'b1);
      n = 0;
      while (acc_total < accept_limit && n < 30) begin step(); n++; end
      n_checks++;
      if (acc_total != accept_limit) begin n_fail++; $display("FAIL mid_issue got=%0d short want=0", accept_limit - acc_total); end
      step();
      reset = 1'b1;
      exp_addr.delete();
      fwd_ok = 1'b0;
      bench_out = 0;
      step();
      reset = 1'b0;
      n_checks += 7;
      if (ddr_cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL mid_ready got=%b want=1", ddr_cmd_ready); end
      if (app_en !== 1'b0)            begin n_fail++; $display("FAIL mid_app_en got=%b want=0", app_en); end
      if (app_addr !== '0)            begin n_fail++; $display("FAIL mid_app_addr got=%h want=0", app_addr); end
      if (ddr_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid got=%b want=0", ddr_rd_data_valid); end
      if (cmd_done !== 1'b0)          begin n_fail++; $display("FAIL mid_cmd_done got=%b want=0", cmd_done); end
      if (ddr_rd_data !== '0)         begin n_fail++; $display("FAIL mid_rd_data got=%h want=0", ddr_rd_data[63:0]); end
      if (rd_spurious_err !== 1'b0)   begin n_fail++; $display("FAIL mid_spurious_clear got=%b want=0", rd_spurious_err); end
      hold_until = 0;
      repeat (8) step();
      n_checks += 4;
      if (rd_spurious_err !== 1'b1)   begin n_fail++; $display("FAIL late_spurious got=%b want=1", rd_spurious_err); end
      if (fwd_cnt != f0)              begin n_fail++; $display("FAIL late_forwarded got=%0d want=0", fwd_cnt - f0); end
      if (ddr_rd_data !== '0)         begin n_fail++; $display("FAIL late_rd_data got=%h want=0", ddr_rd_data[63:0]); end
      if (app_en !== 1'b0 || ddr_cmd_ready !== 1'b1)
                                      begin n_fail++; $display("FAIL late_idle got=en %b rdy %b want=en 0 rdy 1", app_en, ddr_cmd_ready); end
      accept_limit = 32'h7fffffff;
      fwd_ok = 1'b1;
   endtask

   initial begin
      reset = 1'b1; valid_cmd = 1'b0; base_in = '0; len_in = '0;
      app_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
      test_reset();
      test_basic();
      test_outstanding();
      test_rdy_toggle();
      test_zero_len();
      test_ignore();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
